if_id_latch: RTL and testbench

// - Parametrised IF->ID pipeline register; successor to the plain fetch latch.
// - Adds a valid/ready handshake, stall back-pressure and flush (NOP bubble) to the latch.
// - Adds a saturating stall counter.
// - Sits between the fetch unit (PC/instruction memory) and the decode stage.
// - Preserves order and is lossless except on flush.

---
 rtl/if_id_latch_pkg.sv | 16 +
 rtl/if_id_latch_sat_counter.sv | 20 ++
 rtl/if_id_latch.sv | 109 ++++++++++
 tb/tb_if_id_latch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_latch_pkg.sv
// rtl/if_id_latch_pkg.sv - shared IF/ID latch widths, NOP encoding and fetch-beat type
package if_id_latch_pkg;

    localparam int unsigned IF_ID_INSTR_W = 16;
    localparam int unsigned IF_ID_PC_W    = 16;
    localparam int unsigned IF_ID_CNT_W   = 16;

    localparam logic [IF_ID_INSTR_W-1:0] IF_ID_NOP_INSTR = 16'h0000;

    // Default-width fetch beat; latches with other widths declare their own.
    typedef struct packed {
        logic [IF_ID_INSTR_W-1:0] instr;
        logic [IF_ID_PC_W-1:0]    pc;
    } fetch_beat_t;

endpackage

// File: rtl/if_id_latch_sat_counter.sv
// rtl/if_id_latch_sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, clear (sync, wins over inc), inc, count[CNT_W-1:0] (holds at all-ones)
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_latch.sv
// rtl/if_id_latch.sv - IF->ID pipeline register with handshake, flush and stall counter
// Ports: clk, rst (sync, active-high); in_valid/in_ready/instruction/PC from fetch;
//        flush; out_valid/out_ready/instr_out/PC_out to decode; stall_cnt.
// Build option: IF_ID_LATCH_SKID_EN adds a 1-entry skid so in_ready is registered.
module if_id_latch
    import if_id_latch_pkg::*;
#(
    parameter int unsigned         INSTR_W   = IF_ID_INSTR_W,
    parameter int unsigned         PC_W      = IF_ID_PC_W,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(IF_ID_NOP_INSTR),
    parameter int unsigned         CNT_W     = IF_ID_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [PC_W-1:0]    PC,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    PC_out,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } beat_t;

    beat_t in_beat;
    beat_t src_beat;
    logic  src_valid;
    logic  accept;
    logic  load;

    assign in_beat = '{instr: instruction, pc: PC};
    assign accept  = in_valid && in_ready;
    // Output register may take a new beat when empty or being consumed.
    assign load    = !out_valid || out_ready;

`ifdef IF_ID_LATCH_SKID_EN
    logic  skid_valid;
    beat_t skid_q;

    // Registered ready: only the skid occupancy matters, cutting out_ready->in_ready.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            skid_valid <= 1'b0;
        end else if (load) begin
            // Any held skid beat moves to the output now; a full skid blocks accept.
            skid_valid <= 1'b0;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_q     <= in_beat;
        end
    end

    always_comb begin
        src_beat  = in_beat;
        src_valid = accept;
        if (skid_valid) begin
            src_beat  = skid_q;
            src_valid = 1'b1;
        end
    end
`else
    assign in_ready = load;

    always_comb begin
        src_beat  = in_beat;
        src_valid = accept;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            instr_out <= NOP_INSTR;
            PC_out    <= '0;
        end else if (flush) begin
            // PC_out is deliberately left alone; only the instruction becomes a bubble.
            out_valid <= 1'b0;
            instr_out <= NOP_INSTR;
        end else if (load) begin
            if (src_valid) begin
                out_valid <= 1'b1;
                instr_out <= src_beat.instr;
                PC_out    <= src_beat.pc;
            end else begin
                out_valid <= 1'b0;
                instr_out <= NOP_INSTR;
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clear(rst),
        .inc  (out_valid && !out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_if_id_latch.sv
// tb/tb_if_id_latch.sv - self-checking bench for if_id_latch (both skid builds)
module tb_if_id_latch;

`ifdef IF_ID_LATCH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] instruction = '0;
    logic [15:0] PC = '0;

    logic        in_ready, out_valid;
    logic [15:0] instr_out, PC_out, stall_cnt;
    logic        in_ready_s, out_valid_s;
    logic [15:0] instr_out_s, PC_out_s;
    logic [3:0]  stall_cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_latch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .PC(PC), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_out(instr_out), .PC_out(PC_out), .stall_cnt(stall_cnt)
    );

    if_id_latch #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .instruction(instruction), .PC(PC), .flush(flush),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .instr_out(instr_out_s), .PC_out(PC_out_s), .stall_cnt(stall_cnt_s)
    );

    // Reference model: ordered list of held beats {instr,pc}, front is what decode sees.
    logic [31:0] held_q[$];
    logic [15:0] m_pc = '0;
    int          m_cnt = 0;
    int          m_cnt4 = 0;

    function automatic bit m_rdy();
        return (held_q.size() < CAP) || ((CAP == 1) && out_ready);
    endfunction

    function automatic bit m_valid();
        return held_q.size() > 0;
    endfunction

    function automatic logic [15:0] m_instr();
        return (held_q.size() > 0) ? held_q[0][31:16] : 16'h0000;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        rdy = m_rdy();
        if (rst) begin
            held_q.delete();
            m_pc   = '0;
            m_cnt  = 0;
            m_cnt4 = 0;
        end else begin
            if (held_q.size() > 0 && !out_ready) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush) begin
                held_q.delete();
            end else begin
                if (held_q.size() > 0 && out_ready) void'(held_q.pop_front());
                if (in_valid && rdy) held_q.push_back({instruction, PC});
            end
            if (held_q.size() > 0) m_pc = held_q[0][15:0];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; instruction = 16'hA0FF; PC = 16'h00FF;
        out_ready = 1'b1; flush = 1'b0;
        cyc();
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", instr_out); end
        checks++; if (PC_out !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", PC_out); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept got %0b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instruction = 16'hA000 + 16'(i); PC = 16'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
            cyc();
            checks++; if (out_valid !== 1'b1 || instr_out !== 16'hA000 + 16'(i) || PC_out !== 16'(i)) begin
                errors++; $display("FAIL stream_beat[%0d] got v=%0b %h/%h want v=1 %h/%h",
                                   i, out_valid, instr_out, PC_out, 16'hA000 + 16'(i), 16'(i));
            end
        end
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0 || instr_out !== 16'h0000 || PC_out !== 16'h0003) begin
            errors++; $display("FAIL stream_drain got v=%0b %h/%h want v=0 0000/0003", out_valid, instr_out, PC_out);
        end
    endtask

    task automatic test_stall();
        int accepted;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instruction = 16'hA005; PC = 16'h0005;
        cyc();
        out_ready = 1'b0; instruction = 16'hA006; PC = 16'h0006;
        accepted = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (in_ready) accepted++;
            cyc();
            checks++; if (out_valid !== 1'b1 || instr_out !== 16'hA005 || PC_out !== 16'h0005) begin
                errors++; $display("FAIL stall_stable[%0d] got v=%0b %h/%h want v=1 A005/0005", k, out_valid, instr_out, PC_out);
            end
        end
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt got %0d want 4", stall_cnt); end
        checks++; if (accepted != CAP - 1) begin errors++; $display("FAIL stall_accepts got %0d want %0d", accepted, CAP - 1); end
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0b want 0", in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== (CAP == 2) || instr_out !== ((CAP == 2) ? 16'hA006 : 16'h0000)) begin
            errors++; $display("FAIL stall_release got v=%0b %h want v=%0b %h", out_valid, instr_out,
                               CAP == 2, (CAP == 2) ? 16'hA006 : 16'h0000);
        end
    endtask

    task automatic test_flush();
        int delivered;
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; instruction = 16'hA005; PC = 16'h0005;
        cyc();
        instruction = 16'hA006; PC = 16'h0006;
        cyc();
        flush = 1'b1; instruction = 16'hA007; PC = 16'h0007;
        cyc();
        checks++; if (out_valid !== 1'b0 || instr_out !== 16'h0000 || PC_out !== 16'h0005) begin
            errors++; $display("FAIL flush_bubble got v=%0b %h/%h want v=0 0000/0005", out_valid, instr_out, PC_out);
        end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_keeps_cnt got %0d want 2", stall_cnt); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        delivered = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (out_valid) delivered++;
        end
        checks++; if (delivered != 0) begin errors++; $display("FAIL flush_no_delivery got %0d want 0", delivered); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instruction = 16'hA008; PC = 16'h0008;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            checks++; if (stall_cnt_s !== 4'((i < 15) ? i : 15)) begin
                errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, stall_cnt_s, (i < 15) ? i : 15);
            end
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++; if (stall_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_after_flush got %0d want 15", stall_cnt_s); end
        checks++; if (stall_cnt !== 16'd21) begin errors++; $display("FAIL wide_cnt got %0d want 21", stall_cnt); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (stall_cnt_s !== 4'd0) begin errors++; $display("FAIL sat_rst got %0d want 0", stall_cnt_s); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 31) == 0);
            instruction = 16'($urandom);
            PC          = 16'($urandom);
            #1;
            checks++; if (in_ready !== m_rdy() || in_ready_s !== m_rdy()) begin
                errors++; $display("FAIL rand_in_ready[%0d] got %0b/%0b want %0b", n, in_ready, in_ready_s, m_rdy());
            end
            cyc();
            checks++; if (out_valid !== m_valid() || instr_out !== m_instr() || PC_out !== m_pc) begin
                errors++; $display("FAIL rand_out[%0d] got v=%0b %h/%h want v=%0b %h/%h",
                                   n, out_valid, instr_out, PC_out, m_valid(), m_instr(), m_pc);
            end
            checks++; if (out_valid_s !== m_valid() || instr_out_s !== m_instr() || PC_out_s !== m_pc) begin
                errors++; $display("FAIL rand_out_s[%0d] got v=%0b %h/%h want v=%0b %h/%h",
                                   n, out_valid_s, instr_out_s, PC_out_s, m_valid(), m_instr(), m_pc);
            end
            checks++; if (stall_cnt !== 16'(m_cnt) || stall_cnt_s !== 4'(m_cnt4)) begin
                errors++; $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", n, stall_cnt, stall_cnt_s, m_cnt, m_cnt4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
